// File: rtl/seg_share_ctrl.sv
// ============================================================================
//  Module   : seg_share_ctrl
//  Purpose  : Time-shares one 6-digit seven-segment display between NSRC
//             requesters. Ownership rotates round-robin with a programmable
//             dwell per owner. Decimal values are converted to packed BCD by
//             a sequential shift-add-3 (double-dabble) engine over 24 cycles.
//             Hex values are shown as their raw nibbles.
//  Ports    : iCLK    - system clock, rising edge
//             iRST    - synchronous active-high reset
//             iReq    - per-source display request (level)
//             iNum    - source k value at [24k+23:24k]
//             iIsHex  - per-source mode, 1 = raw hex, 0 = decimal
//             iHold   - freeze rotation on the current owner
//             oDigits - six packed nibbles, digit 0 at [3:0]
//             oSrc    - index of the current owner
//             oValid  - oDigits holds a completed value
//             oOvf    - decimal value was clamped to DMAX
//             oBusy   - BCD conversion in progress
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_share_ctrl #(
  parameter int NSRC  = 4,
  parameter int DWELL = 12500000,
  parameter int DMAX  = 999999
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [NSRC-1:0]      iReq,
  input  logic [24*NSRC-1:0]   iNum,
  input  logic [NSRC-1:0]      iIsHex,
  input  logic                 iHold,
  output logic [23:0]          oDigits,
  output logic [2:0]           oSrc,
  output logic                 oValid,
  output logic                 oOvf,
  output logic                 oBusy
);

  localparam int              DW_W     = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DWELL - 1);
  localparam logic [23:0]     DMAX_V   = 24'(DMAX);
  localparam logic [4:0]      CONV_END = 5'd23;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PICK  = 3'd1,
    S_LATCH = 3'd2,
    S_CONV  = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t            state_q;
  logic [2:0]        src_q;
  logic [2:0]        last_q;
  logic [23:0]       digits_q;
  logic              valid_q;
  logic              ovf_q;
  logic              busy_q;
  logic [DW_W-1:0]   dwell_q;
  logic [4:0]        conv_cnt_q;
  logic [47:0]       shift_q;

  logic [47:0]       shift_d;
  logic [23:0]       bcd_adj_d;
  logic [2:0]        grant_d;
  logic              found_d;
  logic [3:0]        idx_d;
  logic              own_req_d;
  logic              own_hex_d;
  logic [23:0]       own_num_d;
  logic [23:0]       clamp_d;

  // Owner's request, mode and value selected by a compare loop so the index
  // width never has to match the vector width.
  always_comb begin
    own_req_d = 1'b0;
    own_hex_d = 1'b0;
    own_num_d = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (src_q == 3'(k)) begin
        own_req_d = iReq[k];
        own_hex_d = iIsHex[k];
        own_num_d = iNum[24*k +: 24];
      end
    end
  end

  // Round-robin scan starting one past the last grant, wrapping modulo NSRC.
  always_comb begin
    found_d = 1'b0;
    grant_d = '0;
    idx_d   = '0;
    for (int i = 0; i < NSRC; i++) begin
      idx_d = {1'b0, last_q} + 4'(i + 1);
      if (idx_d >= 4'(NSRC)) begin
        idx_d = idx_d - 4'(NSRC);
      end
      for (int k = 0; k < NSRC; k++) begin
        if (!found_d && iReq[k] && (idx_d == 4'(k))) begin
          found_d = 1'b1;
          grant_d = 3'(k);
        end
      end
    end
  end

  assign clamp_d = (own_num_d > DMAX_V) ? DMAX_V : own_num_d;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  always_comb begin
    bcd_adj_d = shift_q[47:24];
    for (int n = 0; n < 6; n++) begin
      if (bcd_adj_d[4*n +: 4] >= 4'd5) begin
        bcd_adj_d[4*n +: 4] = bcd_adj_d[4*n +: 4] + 4'd3;
      end
    end
    shift_d = {bcd_adj_d, shift_q[23:0]} << 1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      last_q     <= 3'(NSRC - 1);
      digits_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      dwell_q    <= '0;
      conv_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q  <= 1'b0;
          digits_q <= '0;
          if (|iReq) begin
            state_q <= S_PICK;
          end
        end

        S_PICK: begin
          dwell_q <= '0;
          if (found_d) begin
            src_q   <= grant_d;
            last_q  <= grant_d;
            state_q <= S_LATCH;
          end else begin
            valid_q  <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
          end
        end

        S_LATCH: begin
          dwell_q <= '0;
          if (own_hex_d) begin
            digits_q <= own_num_d;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= S_SHOW;
          end else begin
            ovf_q      <= (own_num_d > DMAX_V);
            shift_q    <= {24'd0, clamp_d};
            conv_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_CONV;
          end
        end

        S_CONV: begin
          if (!own_req_d) begin
            // Abort: displayed digits stay as they were until the next owner completes.
            busy_q  <= 1'b0;
            dwell_q <= '0;
            state_q <= S_PICK;
          end else begin
            shift_q    <= shift_d;
            conv_cnt_q <= conv_cnt_q + 5'd1;
            if (conv_cnt_q == CONV_END) begin
              digits_q <= shift_d[47:24];
              valid_q  <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= S_SHOW;
            end
          end
        end

        S_SHOW: begin
          if (!own_req_d) begin
            dwell_q <= '0;
            state_q <= S_PICK;
          end else if (!iHold) begin
            if (dwell_q == DW_LAST) begin
              dwell_q <= '0;
              state_q <= S_PICK;
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oDigits = digits_q;
  assign oSrc    = src_q;
  assign oValid  = valid_q;
  assign oOvf    = ovf_q;
  assign oBusy   = busy_q;

endmodule

`default_nettype wire
